estagio_busca: RTL and testbench

Instruction-fetch (IF) stage of the pipelined processor. Holds the program counter and drives the word-addressed instruction memory (`memoriaBloco`) through its `memEndereco`/`lerMemoria` inputs. Captures the memory's `saida` into the IF/ID pipeline register. Supports decode-stage stalls, branch/jump redirects with flush, and a sticky fault when the PC leaves the memory's address range.

---
 rtl/estagio_busca.sv | 97 +++++++++
 tb/tb_estagio_busca.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory read port
// and captures the fetched word into the IF/ID register.
module estagio_busca #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 1501,
  parameter int PC_INICIAL   = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               parar,
  input  logic               desviar,
  input  logic [LARGURA-1:0] alvoDesvio,
  input  logic [LARGURA-1:0] memDado,
  output logic [LARGURA-1:0] memEndereco,
  output logic               lerMemoria,
  output logic [LARGURA-1:0] instrucao,
  output logic [LARGURA-1:0] pcInstrucao,
  output logic               valido,
  output logic               erroEndereco
);

  localparam logic [LARGURA-1:0] LIMITE  = LARGURA'(PROFUNDIDADE);
  localparam logic [LARGURA-1:0] PC_RST  = LARGURA'(PC_INICIAL);
  localparam logic [LARGURA-1:0] UM      = LARGURA'(1);

  typedef enum logic [1:0] {INICIO, BUSCA, ERRO} tipoEstado;

  tipoEstado          estadoReg, estadoNext;
  logic [LARGURA-1:0] pcReg, pcNext;
  logic [LARGURA-1:0] instrucaoReg, instrucaoNext;
  logic [LARGURA-1:0] pcInstrucaoReg, pcInstrucaoNext;
  logic               validoReg, validoNext;
  logic               erroReg, erroNext;
  logic               pcNoLimite;

  assign pcNoLimite   = (pcReg < LIMITE);
  assign memEndereco  = pcReg;
  assign lerMemoria   = (estadoReg == BUSCA) && pcNoLimite;
  assign instrucao    = instrucaoReg;
  assign pcInstrucao  = pcInstrucaoReg;
  assign valido       = validoReg;
  assign erroEndereco = erroReg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estadoReg      <= INICIO;
      pcReg          <= PC_RST;
      instrucaoReg   <= '0;
      pcInstrucaoReg <= '0;
      validoReg      <= 1'b0;
      erroReg        <= 1'b0;
    end else begin
      estadoReg      <= estadoNext;
      pcReg          <= pcNext;
      instrucaoReg   <= instrucaoNext;
      pcInstrucaoReg <= pcInstrucaoNext;
      validoReg      <= validoNext;
      erroReg        <= erroNext;
    end
  end

  always_comb begin
    estadoNext      = estadoReg;
    pcNext          = pcReg;
    instrucaoNext   = instrucaoReg;
    pcInstrucaoNext = pcInstrucaoReg;
    validoNext      = validoReg;
    erroNext        = erroReg;
    unique case (estadoReg)
      INICIO: estadoNext = BUSCA;
      BUSCA: begin
        // Redirect outranks the range check so an out-of-range PC can still be steered back.
        if (desviar) begin
          pcNext        = alvoDesvio;
          instrucaoNext = '0;
          validoNext    = 1'b0;
        end else if (!pcNoLimite) begin
          erroNext      = 1'b1;
          validoNext    = 1'b0;
          instrucaoNext = '0;
          estadoNext    = ERRO;
        end else if (!parar) begin
          instrucaoNext   = memDado;
          pcInstrucaoNext = pcReg;
          validoNext      = 1'b1;
          pcNext          = pcReg + UM;
        end
      end
      ERRO: begin
        validoNext = 1'b0;
        erroNext   = 1'b1;
      end
      default: estadoNext = INICIO;
    endcase
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: memory model holds Bloco[i]=i; a second
// instance checks a non-zero PC_INICIAL.
`timescale 1ns/1ps
module tb_estagio_busca;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        parar = 1'b0;
  logic        desviar = 1'b0;
  logic [31:0] alvoDesvio = '0;
  logic [31:0] memDado, memEndereco, instrucao, pcInstrucao;
  logic        lerMemoria, valido, erroEndereco;
  logic [31:0] memDado2, memEndereco2, instrucao2, pcInstrucao2;
  logic        lerMemoria2, valido2, erroEndereco2;
  logic [31:0] bloco [0:1500];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign memDado  = (memEndereco  < 32'd1501) ? bloco[memEndereco[10:0]]  : 32'hDEADBEEF;
  assign memDado2 = (memEndereco2 < 32'd1501) ? bloco[memEndereco2[10:0]] : 32'hDEADBEEF;

  estagio_busca dut (
    .clock(clock), .reset(reset), .parar(parar), .desviar(desviar),
    .alvoDesvio(alvoDesvio), .memDado(memDado), .memEndereco(memEndereco),
    .lerMemoria(lerMemoria), .instrucao(instrucao), .pcInstrucao(pcInstrucao),
    .valido(valido), .erroEndereco(erroEndereco)
  );

  estagio_busca #(.PC_INICIAL(20)) dut20 (
    .clock(clock), .reset(reset), .parar(parar), .desviar(desviar),
    .alvoDesvio(alvoDesvio), .memDado(memDado2), .memEndereco(memEndereco2),
    .lerMemoria(lerMemoria2), .instrucao(instrucao2), .pcInstrucao(pcInstrucao2),
    .valido(valido2), .erroEndereco(erroEndereco2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic soltarReset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (memEndereco !== 32'd0 || instrucao !== 32'd0 || pcInstrucao !== 32'd0 ||
        valido !== 1'b0 || erroEndereco !== 1'b0 || lerMemoria !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%0d instr=%0d pcI=%0d val=%b err=%b rd=%b, want all 0",
               memEndereco, instrucao, pcInstrucao, valido, erroEndereco, lerMemoria);
    end
    checks++;
    if (memEndereco2 !== 32'd20) begin
      errors++;
      $display("FAIL reset_pc20: pc=%0d want 20", memEndereco2);
    end
    $display("reset checked: pc=%0d pc20=%0d", memEndereco, memEndereco2);
  endtask

  task automatic test_sequential();
    soltarReset();
    tick();
    checks++;
    if (valido !== 1'b0 || lerMemoria !== 1'b1 || memEndereco !== 32'd0) begin
      errors++;
      $display("FAIL settle: val=%b rd=%b pc=%0d want 0 1 0", valido, lerMemoria, memEndereco);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instrucao !== 32'(i) || pcInstrucao !== 32'(i) || valido !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d: instr=%0d pcI=%0d val=%b want %0d %0d 1",
                 i, instrucao, pcInstrucao, valido, i, i);
      end
      $display("fetch: instr=%0d pcI=%0d val=%b", instrucao, pcInstrucao, valido);
      if (i == 0) begin
        checks++;
        if (instrucao2 !== 32'd20 || pcInstrucao2 !== 32'd20 || valido2 !== 1'b1) begin
          errors++;
          $display("FAIL pc_inicial20: instr=%0d pcI=%0d val=%b want 20 20 1",
                   instrucao2, pcInstrucao2, valido2);
        end
      end
    end
    tick();  // captures 4, pc becomes 5
  endtask

  task automatic test_stall();
    parar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instrucao !== 32'd4 || memEndereco !== 32'd5 || lerMemoria !== 1'b1 || valido !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: instr=%0d pc=%0d rd=%b val=%b want 4 5 1 1",
                 i, instrucao, memEndereco, lerMemoria, valido);
      end
    end
    parar = 1'b0;
    tick();
    checks++;
    if (instrucao !== 32'd5 || pcInstrucao !== 32'd5 || memEndereco !== 32'd6) begin
      errors++;
      $display("FAIL stall_release: instr=%0d pcI=%0d pc=%0d want 5 5 6",
               instrucao, pcInstrucao, memEndereco);
    end
    $display("stall released: instr=%0d pcI=%0d", instrucao, pcInstrucao);
  endtask

  task automatic test_redirect();
    repeat (4) tick();  // captures 6..9, pc=10
    desviar = 1'b1; parar = 1'b1; alvoDesvio = 32'd100;
    tick();
    checks++;
    if (valido !== 1'b0 || instrucao !== 32'd0 || memEndereco !== 32'd100 || pcInstrucao !== 32'd9) begin
      errors++;
      $display("FAIL redirect_flush: val=%b instr=%0d pc=%0d pcI=%0d want 0 0 100 9",
               valido, instrucao, memEndereco, pcInstrucao);
    end
    desviar = 1'b0; parar = 1'b0;
    tick();
    checks++;
    if (instrucao !== 32'd100 || pcInstrucao !== 32'd100 || valido !== 1'b1) begin
      errors++;
      $display("FAIL redirect_target: instr=%0d pcI=%0d val=%b want 100 100 1",
               instrucao, pcInstrucao, valido);
    end
    $display("redirect: instr=%0d pcI=%0d", instrucao, pcInstrucao);
  endtask

  task automatic test_range_fault();
    desviar = 1'b1; alvoDesvio = 32'd1500;
    tick();
    desviar = 1'b0;
    tick();
    checks++;
    if (instrucao !== 32'd1500 || valido !== 1'b1 || memEndereco !== 32'd1501 || lerMemoria !== 1'b0) begin
      errors++;
      $display("FAIL last_word: instr=%0d val=%b pc=%0d rd=%b want 1500 1 1501 0",
               instrucao, valido, memEndereco, lerMemoria);
    end
    tick();
    checks++;
    if (erroEndereco !== 1'b1 || valido !== 1'b0 || instrucao !== 32'd0) begin
      errors++;
      $display("FAIL fault: err=%b val=%b instr=%0d want 1 0 0", erroEndereco, valido, instrucao);
    end
    desviar = 1'b1; alvoDesvio = 32'd0;
    repeat (2) tick();
    desviar = 1'b0;
    checks++;
    if (erroEndereco !== 1'b1 || memEndereco !== 32'd1501 || lerMemoria !== 1'b0 || valido !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: err=%b pc=%0d rd=%b val=%b want 1 1501 0 0",
               erroEndereco, memEndereco, lerMemoria, valido);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (erroEndereco !== 1'b0 || memEndereco !== 32'd0) begin
      errors++;
      $display("FAIL fault_reset: err=%b pc=%0d want 0 0", erroEndereco, memEndereco);
    end
    $display("fault cleared by reset: err=%b", erroEndereco);
  endtask

  task automatic test_async_reset();
    soltarReset();
    repeat (38) tick();  // edge0 settle, then 37 fetches: pc=37
    checks++;
    if (memEndereco !== 32'd37 || instrucao !== 32'd36) begin
      errors++;
      $display("FAIL run_to_37: pc=%0d instr=%0d want 37 36", memEndereco, instrucao);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (valido !== 1'b0 || instrucao !== 32'd0 || erroEndereco !== 1'b0 ||
        lerMemoria !== 1'b0 || memEndereco !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: val=%b instr=%0d err=%b rd=%b pc=%0d want 0 0 0 0 0",
               valido, instrucao, erroEndereco, lerMemoria, memEndereco);
    end
    soltarReset();
    repeat (2) tick();
    checks++;
    if (instrucao !== 32'd0 || pcInstrucao !== 32'd0 || valido !== 1'b1) begin
      errors++;
      $display("FAIL restart0: instr=%0d pcI=%0d val=%b want 0 0 1", instrucao, pcInstrucao, valido);
    end
    tick();
    checks++;
    if (instrucao !== 32'd1 || pcInstrucao !== 32'd1) begin
      errors++;
      $display("FAIL restart1: instr=%0d pcI=%0d want 1 1", instrucao, pcInstrucao);
    end
    $display("restart: instr=%0d pcI=%0d", instrucao, pcInstrucao);
  endtask

  initial begin
    for (int i = 0; i < 1501; i++) bloco[i] = 32'(i);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_range_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
